dc_fifo_wr_arb: RTL and testbench



---
 rtl/dc_fifo_wr_arb.sv | 105 ++++++++++
 tb/tb_dc_fifo_wr_arb.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_fifo_wr_arb.sv
// Round-robin packet-locked write arbiter for a shared dc_fifo port.
// Words are tagged {grant index, payload} for read-side demux.
module dc_fifo_wr_arb #(
  parameter int N_REQ     = 4,
  parameter int DW        = 16,
  parameter int MAX_BEATS = 256,
  localparam int IDW      = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ-1:0]    req_last,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic [IDW+DW-1:0]   fifo_wr_din,
  output logic                fifo_wr_write,
  input  logic                fifo_wr_full,
  output logic                busy,
  output logic [IDW-1:0]      grant_id,
  output logic [15:0]         pkt_count,
  output logic                err_overlong
);

  localparam int BCW = $clog2(MAX_BEATS) + 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]     state;
  logic [IDW-1:0] rr_ptr;
  logic [BCW-1:0] beat_cnt;
  logic [IDW-1:0] win;
  logic           any_req;
  logic           own;
  logic           beat_last;
  logic [IDW-1:0] rr_next;

  // lowest offset from rr_ptr wins, so scan offsets high to low
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (req_valid[idx]) begin
        win     = IDW'(idx);
        any_req = 1'b1;
      end
    end
  end

  assign own       = rstn && (state == BURST);
  assign busy      = (state == BURST);
  assign beat_last = req_last[grant_id];
  assign rr_next   = (int'(grant_id) == N_REQ - 1) ?
                     '0 : grant_id + 1'b1;

  always_comb begin
    req_ready = '0;
    if (own && !fifo_wr_full)
      req_ready[grant_id] = 1'b1;
  end

  assign fifo_wr_write = own && req_valid[grant_id]
                       && !fifo_wr_full;
  assign fifo_wr_din   = {grant_id,
                          req_data[grant_id*DW +: DW]};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      grant_id     <= '0;
      rr_ptr       <= '0;
      beat_cnt     <= '0;
      pkt_count    <= '0;
      err_overlong <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            grant_id <= win;
            state    <= BURST;
          end
        end
        BURST: begin
          if (fifo_wr_write) begin
            if (beat_last) begin
              state     <= IDLE;
              beat_cnt  <= '0;
              pkt_count <= pkt_count + 16'd1;
              rr_ptr    <= rr_next;
            end else begin
              if (beat_cnt != BCW'(MAX_BEATS))
                beat_cnt <= beat_cnt + 1'b1;
              if (beat_cnt >= BCW'(MAX_BEATS - 1))
                err_overlong <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dc_fifo_wr_arb.sv
// Bench for dc_fifo_wr_arb: packet-level model checked every cycle,
// plus literal checks on the captured fifo word stream.
module tb_dc_fifo_wr_arb;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int MB  = 8;
  localparam int IDW = 2;

  logic              clk;
  logic              rstn;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_last;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic [IDW+DW-1:0] fifo_wr_din;
  logic              fifo_wr_write;
  logic              fifo_wr_full;
  logic              busy;
  logic [IDW-1:0]    grant_id;
  logic [15:0]       pkt_count;
  logic              err_overlong;

  int checks   = 0;
  int failures = 0;

  logic [IDW+DW-1:0] wlog[$];

  dc_fifo_wr_arb #(.N_REQ(N), .DW(DW), .MAX_BEATS(MB)) dut (
    .clk(clk),
    .rstn(rstn),
    .req_valid(req_valid),
    .req_last(req_last),
    .req_data(req_data),
    .req_ready(req_ready),
    .fifo_wr_din(fifo_wr_din),
    .fifo_wr_write(fifo_wr_write),
    .fifo_wr_full(fifo_wr_full),
    .busy(busy),
    .grant_id(grant_id),
    .pkt_count(pkt_count),
    .err_overlong(err_overlong)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // packet-level model: owner is -1 when no packet is granted
  int   m_own   = -1;
  int   m_gid   = 0;
  int   m_rr    = 0;
  int   m_beats = 0;
  int   m_pkt   = 0;
  bit   m_err   = 0;
  logic [N-1:0]      e_rdy;
  logic              e_wr;
  logic [IDW+DW-1:0] e_din;

  always @(negedge clk) begin
    e_rdy = '0;
    e_wr  = 1'b0;
    e_din = '0;
    if (rstn && m_own >= 0) begin
      e_rdy[m_own] = !fifo_wr_full;
      e_wr  = req_valid[m_own] && !fifo_wr_full;
      e_din = {IDW'(m_own), req_data[m_own*DW +: DW]};
    end
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    chk("fifo_wr_write", 32'(fifo_wr_write), 32'(e_wr));
    if (e_wr) chk("fifo_wr_din", 32'(fifo_wr_din), 32'(e_din));
    chk("busy", 32'(busy), 32'(m_own >= 0));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("pkt_count", 32'(pkt_count), 32'(m_pkt % 65536));
    chk("err_overlong", 32'(err_overlong), 32'(m_err));
    if (fifo_wr_write) wlog.push_back(fifo_wr_din);
    // advance the model across the coming edge
    if (!rstn) begin
      m_own = -1; m_gid = 0; m_rr = 0;
      m_beats = 0; m_pkt = 0; m_err = 0;
    end else if (m_own < 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_own < 0 && req_valid[(m_rr + k) % N]) begin
          m_own = (m_rr + k) % N;
          m_gid = m_own;
        end
      end
    end else if (e_wr) begin
      m_beats++;
      if (req_last[m_own]) begin
        m_pkt++;
        m_rr    = (m_own + 1) % N;
        m_own   = -1;
        m_beats = 0;
      end else if (m_beats >= MB) begin
        m_err = 1;
      end
    end
  end

  task automatic wait_rdy(input int src);
    int t = 0;
    @(negedge clk);
    while (!req_ready[src] && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (t >= 100) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout src=%0d actual=0 required=1",
               src);
    end
  endtask

  task automatic send(input int src, input int n,
                      input int gap_at, input int stall_at);
    for (int b = 0; b < n; b++) begin
      if (b == gap_at) begin
        req_valid[src] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
      end
      req_valid[src] = 1'b1;
      req_last[src]  = (b == n - 1);
      req_data[src*DW +: DW] = DW'(src * 256 + b);
      if (b == stall_at) begin
        fifo_wr_full = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        fifo_wr_full = 1'b0;
      end
      wait_rdy(src);
      @(posedge clk);
      #1;
    end
    req_valid[src] = 1'b0;
    req_last[src]  = 1'b0;
  endtask

  logic [IDW+DW-1:0] w;

  initial begin
    rstn         = 1'b0;
    req_valid    = '1;
    req_last     = '1;
    fifo_wr_full = 1'b0;
    for (int i = 0; i < N; i++)
      req_data[i*DW +: DW] = DW'(16'hA000 + i);

    // reset held with all requesters valid
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    wlog.delete();
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("first_busy", 32'(busy), 32'd1);
    chk("first_grant", 32'(grant_id), 32'd0);

    // fairness: 16 cycles of single-beat packets from everyone
    repeat (15) @(posedge clk);
    #1;
    req_valid = '0;
    req_last  = '0;
    @(negedge clk);
    chk("fair_pkts", 32'(pkt_count), 32'd8);
    chk("fair_words", 32'(wlog.size()), 32'd8);
    for (int i = 0; i < 8 && i < wlog.size(); i++) begin
      w = wlog[i];
      chk("fair_word", 32'(w), 32'({IDW'(i % 4), 16'hA000} + (i % 4)));
    end

    // packet lock: 1 holds a 5-beat packet while 2 waits
    @(posedge clk);
    #1;
    wlog.delete();
    fork
      send(1, 5, 2, -1);
      send(2, 1, -1, -1);
    join
    repeat (2) @(posedge clk);
    #1;
    chk("lock_words", 32'(wlog.size()), 32'd6);
    for (int i = 0; i < 6 && i < wlog.size(); i++) begin
      w = wlog[i];
      if (i < 5) chk("lock_word", 32'(w), 32'h10100 + i);
      else       chk("lock_tail", 32'(w), 32'h20200);
    end

    // backpressure mid-burst
    wlog.delete();
    send(3, 4, -1, 2);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_words", 32'(wlog.size()), 32'd4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      w = wlog[i];
      chk("bp_word", 32'(w), 32'h30300 + i);
    end
    chk("bp_err", 32'(err_overlong), 32'd0);

    // overlong: 11 beats, last on the 11th
    wlog.delete();
    send(0, 11, -1, -1);
    repeat (2) @(posedge clk);
    #1;
    chk("ovl_err", 32'(err_overlong), 32'd1);
    chk("ovl_pkts", 32'(pkt_count), 32'd12);
    chk("ovl_words", 32'(wlog.size()), 32'd11);
    if (wlog.size() == 11) begin
      w = wlog[10];
      chk("ovl_last", 32'(w), 32'h0000A);
    end

    // reset pulse after 3 accepted beats of a 6-beat packet
    req_valid[2] = 1'b1;
    req_last[2]  = 1'b0;
    for (int b = 0; b < 3; b++) begin
      req_data[2*DW +: DW] = DW'(16'h0200 + b);
      wait_rdy(2);
      @(posedge clk);
      #1;
    end
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    req_valid[0] = 1'b1;
    req_last[0]  = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_err", 32'(err_overlong), 32'd0);
    chk("rst_pkts", 32'(pkt_count), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("regrant_busy", 32'(busy), 32'd1);
    chk("regrant_id", 32'(grant_id), 32'd0);
    @(posedge clk);
    #1;
    req_valid = '0;
    req_last  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("final_pkts", 32'(pkt_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
